// File: rtl/multimode_timekeeper.sv
// multimode_timekeeper
//   Time-of-day clock (HH:MM:SS), lap-capable stopwatch (MM:SS) and optional
//   countdown timer (MM:SS). All three run concurrently from one internal
//   1 s prescaler. i_mode selects which machine receives button pulses and
//   which one drives the display fields.
//
//   Optional feature macro: TK_COUNTDOWN_EN
//     defined   - countdown machine present, i_mode=10 selects it
//     undefined - no countdown logic, i_mode=10 acts as clock mode,
//                 o_expired tied low
//
//   Parameters
//     TICK_DIV  clk cycles per 1 s tick (>=1; 1 ticks every cycle)
//     HR_LIMIT  hour modulus (12 or 24)
//
//   Ports
//     clk, rst         clock, asynchronous active-high reset
//     i_mode[1:0]      00/11 clock, 01 stopwatch, 10 countdown
//     i_add_sec/min/hr set (clock) / preset (countdown) pulses
//     i_start_stop     start/stop pulse
//     i_lap            stopwatch lap hold/release pulse
//     i_clear          stopwatch/countdown clear pulse
//     o_upper[5:0]     HH (clock) or MM (stopwatch/countdown), binary
//     o_lower[5:0]     MM (clock) or SS (stopwatch/countdown), binary
//     o_tick           one-cycle 1 s strobe
//     o_running        selected timekeeper is counting
//     o_lap_active     stopwatch display frozen on lap value
//     o_expired        countdown reached 00:00
module multimode_timekeeper #(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned HR_LIMIT = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_mode,
    input  logic       i_add_sec,
    input  logic       i_add_min,
    input  logic       i_add_hr,
    input  logic       i_start_stop,
    input  logic       i_lap,
    input  logic       i_clear,
    output logic [5:0] o_upper,
    output logic [5:0] o_lower,
    output logic       o_tick,
    output logic       o_running,
    output logic       o_lap_active,
    output logic       o_expired
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    function automatic logic [5:0] wrap60_inc(input logic [5:0] v);
        return (v == 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [11:0] mmss_inc(input logic [5:0] m, input logic [5:0] s);
        if (s != 6'd59) return {m, s + 6'd1};
        return {wrap60_inc(m), 6'd0};
    endfunction

    // ------------------------------------------------------------------
    // Mode decode
    // ------------------------------------------------------------------
    logic sel_clk, sel_sw, sel_cd;

    assign sel_sw  = (i_mode == 2'b01);
`ifdef TK_COUNTDOWN_EN
    assign sel_cd  = (i_mode == 2'b10);
`else
    assign sel_cd  = 1'b0;
`endif
    assign sel_clk = !sel_sw && !sel_cd;

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    logic [PW-1:0] presc_q, presc_d;
    logic          tick;

    // Gated by rst so that TICK_DIV=1 (count permanently at its terminal
    // value) still shows o_tick=0 while reset is held.
    assign tick    = (presc_q == PW'(TICK_DIV - 1)) && !rst;
    assign presc_d = (presc_q == PW'(TICK_DIV - 1)) ? '0 : presc_q + 1'b1;
    assign o_tick  = tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) presc_q <= '0;
        else     presc_q <= presc_d;
    end

    // ------------------------------------------------------------------
    // Time-of-day clock
    // ------------------------------------------------------------------
    logic [5:0] sec_q, sec_d, min_q, min_d, hr_q, hr_d;
    logic       set_sec, set_min, set_hr;
    logic       carry_min, carry_hr;

    assign set_sec = sel_clk && i_add_sec;
    assign set_min = sel_clk && i_add_min;
    assign set_hr  = sel_clk && i_add_hr;

    // A set pulse overrides the tick path of its own field, so that field
    // does not wrap and therefore cannot carry further up.
    assign carry_min = tick && (sec_q == 6'd59) && !set_sec;
    assign carry_hr  = carry_min && (min_q == 6'd59) && !set_min;

    always_comb begin
        sec_d = sec_q;
        min_d = min_q;
        hr_d  = hr_q;
        if (tick)      sec_d = wrap60_inc(sec_q);
        if (carry_min) min_d = wrap60_inc(min_q);
        if (carry_hr)  hr_d  = (hr_q == 6'(HR_LIMIT - 1)) ? 6'd0 : hr_q + 6'd1;
        if (set_sec)   sec_d = '0;
        if (set_min)   min_d = wrap60_inc(min_q);
        if (set_hr)    hr_d  = (hr_q == 6'(HR_LIMIT - 1)) ? 6'd0 : hr_q + 6'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_q <= '0;
            min_q <= '0;
            hr_q  <= '0;
        end else begin
            sec_q <= sec_d;
            min_q <= min_d;
            hr_q  <= hr_d;
        end
    end

    // ------------------------------------------------------------------
    // Stopwatch
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {SW_IDLE, SW_RUN, SW_PAUSE} sw_state_t;

    sw_state_t  sw_state_q;
    logic [5:0] sw_min_q, sw_sec_q, lap_min_q, lap_sec_q;
    logic       lap_q;
    logic       sw_ss, sw_lap, sw_clear;

    assign sw_ss    = sel_sw && i_start_stop;
    assign sw_lap   = sel_sw && i_lap;
    assign sw_clear = sel_sw && i_clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_state_q <= SW_IDLE;
            sw_min_q   <= '0;
            sw_sec_q   <= '0;
            lap_min_q  <= '0;
            lap_sec_q  <= '0;
            lap_q      <= 1'b0;
        end else if (sw_clear) begin
            sw_state_q <= SW_IDLE;
            sw_min_q   <= '0;
            sw_sec_q   <= '0;
            lap_min_q  <= '0;
            lap_sec_q  <= '0;
            lap_q      <= 1'b0;
        end else begin
            // A start/stop pulse swallows a coincident tick in every state.
            if (sw_ss) begin
                sw_state_q <= (sw_state_q == SW_RUN) ? SW_PAUSE : SW_RUN;
            end else if ((sw_state_q == SW_RUN) && tick) begin
                {sw_min_q, sw_sec_q} <= mmss_inc(sw_min_q, sw_sec_q);
            end
            if (sw_lap) begin
                if (lap_q) begin
                    lap_q <= 1'b0;
                end else if (sw_state_q == SW_RUN) begin
                    lap_q     <= 1'b1;
                    lap_min_q <= sw_min_q;
                    lap_sec_q <= sw_sec_q;
                end
            end
        end
    end

    assign o_lap_active = lap_q;

`ifdef TK_COUNTDOWN_EN
    // ------------------------------------------------------------------
    // Countdown
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {CD_SET, CD_RUN, CD_PAUSE, CD_DONE} cd_state_t;

    cd_state_t  cd_state_q;
    logic [5:0] pre_min_q, pre_sec_q, cd_min_q, cd_sec_q;
    logic       cd_ss, cd_clear, cd_last;

    assign cd_ss    = sel_cd && i_start_stop;
    assign cd_clear = sel_cd && i_clear;
    assign cd_last  = (cd_min_q == 6'd0) && (cd_sec_q == 6'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cd_state_q <= CD_SET;
            pre_min_q  <= '0;
            pre_sec_q  <= '0;
            cd_min_q   <= '0;
            cd_sec_q   <= '0;
        end else begin
            case (cd_state_q)
                CD_SET: begin
                    if (!cd_clear) begin
                        if (sel_cd && i_add_sec) pre_sec_q <= wrap60_inc(pre_sec_q);
                        if (sel_cd && i_add_min) pre_min_q <= wrap60_inc(pre_min_q);
                        if (cd_ss && ({pre_min_q, pre_sec_q} != '0)) begin
                            cd_min_q   <= pre_min_q;
                            cd_sec_q   <= pre_sec_q;
                            cd_state_q <= CD_RUN;
                        end
                    end
                end
                CD_RUN: begin
                    // Expiry outranks a coincident pause; otherwise a pause
                    // swallows the tick.
                    if (cd_clear) begin
                        cd_min_q   <= pre_min_q;
                        cd_sec_q   <= pre_sec_q;
                        cd_state_q <= CD_SET;
                    end else if (tick && cd_last) begin
                        cd_sec_q   <= '0;
                        cd_state_q <= CD_DONE;
                    end else if (cd_ss) begin
                        cd_state_q <= CD_PAUSE;
                    end else if (tick) begin
                        if (cd_sec_q != 6'd0) begin
                            cd_sec_q <= cd_sec_q - 6'd1;
                        end else begin
                            cd_min_q <= cd_min_q - 6'd1;
                            cd_sec_q <= 6'd59;
                        end
                    end
                end
                CD_PAUSE: begin
                    if (cd_clear) begin
                        cd_min_q   <= pre_min_q;
                        cd_sec_q   <= pre_sec_q;
                        cd_state_q <= CD_SET;
                    end else if (cd_ss) begin
                        cd_state_q <= CD_RUN;
                    end
                end
                CD_DONE: begin
                    if (cd_clear || cd_ss) begin
                        cd_min_q   <= pre_min_q;
                        cd_sec_q   <= pre_sec_q;
                        cd_state_q <= CD_SET;
                    end
                end
                default: cd_state_q <= CD_SET;
            endcase
        end
    end

    assign o_expired = (cd_state_q == CD_DONE);
`else
    assign o_expired = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Display / status mux
    // ------------------------------------------------------------------
    always_comb begin
        o_upper   = hr_q;
        o_lower   = min_q;
        o_running = 1'b1;
        if (sel_sw) begin
            o_upper   = lap_q ? lap_min_q : sw_min_q;
            o_lower   = lap_q ? lap_sec_q : sw_sec_q;
            o_running = (sw_state_q == SW_RUN);
        end
`ifdef TK_COUNTDOWN_EN
        else if (sel_cd) begin
            // While setting, the preset being edited is what the user sees.
            o_upper   = (cd_state_q == CD_SET) ? pre_min_q : cd_min_q;
            o_lower   = (cd_state_q == CD_SET) ? pre_sec_q : cd_sec_q;
            o_running = (cd_state_q == CD_RUN);
        end
`endif
    end

endmodule

// File: tb/tb_multimode_timekeeper.sv
module tb_multimode_timekeeper;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mode = 2'b00;
    logic       add_sec = 1'b0, add_min = 1'b0, add_hr = 1'b0;
    logic       ss = 1'b0, lap = 1'b0, clr = 1'b0;

    logic [5:0] a_upper, a_lower, b_upper, b_lower, c_upper, c_lower;
    logic       a_tick, a_running, a_lap, a_exp;
    logic       b_tick, b_running, b_lap, b_exp;
    logic       c_tick, c_running, c_lap, c_exp;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    multimode_timekeeper #(.TICK_DIV(4), .HR_LIMIT(24)) dut_a (
        .clk(clk), .rst(rst), .i_mode(mode),
        .i_add_sec(add_sec), .i_add_min(add_min), .i_add_hr(add_hr),
        .i_start_stop(ss), .i_lap(lap), .i_clear(clr),
        .o_upper(a_upper), .o_lower(a_lower), .o_tick(a_tick),
        .o_running(a_running), .o_lap_active(a_lap), .o_expired(a_exp)
    );

    multimode_timekeeper #(.TICK_DIV(4), .HR_LIMIT(12)) dut_b (
        .clk(clk), .rst(rst), .i_mode(mode),
        .i_add_sec(add_sec), .i_add_min(add_min), .i_add_hr(add_hr),
        .i_start_stop(ss), .i_lap(lap), .i_clear(clr),
        .o_upper(b_upper), .o_lower(b_lower), .o_tick(b_tick),
        .o_running(b_running), .o_lap_active(b_lap), .o_expired(b_exp)
    );

    multimode_timekeeper #(.TICK_DIV(1), .HR_LIMIT(24)) dut_c (
        .clk(clk), .rst(rst), .i_mode(mode),
        .i_add_sec(add_sec), .i_add_min(add_min), .i_add_hr(add_hr),
        .i_start_stop(ss), .i_lap(lap), .i_clear(clr),
        .o_upper(c_upper), .o_lower(c_lower), .o_tick(c_tick),
        .o_running(c_running), .o_lap_active(c_lap), .o_expired(c_exp)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // which: 0 sec, 1 min, 2 hr, 3 start_stop, 4 lap, 5 clear
    task automatic pulse(input int unsigned which);
        case (which)
            0: add_sec = 1'b1;
            1: add_min = 1'b1;
            2: add_hr  = 1'b1;
            3: ss      = 1'b1;
            4: lap     = 1'b1;
            default: clr = 1'b1;
        endcase
        cyc(1);
        add_sec = 1'b0; add_min = 1'b0; add_hr = 1'b0;
        ss = 1'b0; lap = 1'b0; clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset values ----------------
        @(posedge clk);
        #2;
        check("rst_a_tick", a_tick, 0);
        check("rst_c_tick", c_tick, 0);
        check("rst_a_upper", a_upper, 0);
        check("rst_a_lower", a_lower, 0);
        check("rst_a_running", a_running, 1);
        check("rst_a_lap", a_lap, 0);
        check("rst_a_exp", a_exp, 0);
        mode = 2'b01;
        #1;
        check("rst_c_sw_running", c_running, 0);
        check("rst_c_sw_upper", c_upper, 0);
        mode = 2'b00;
        #1;
        rst = 1'b0;
        #1;

        // ---------------- prescaler: ticks at cycles 3,7,11 ----------------
        for (int i = 0; i < 12; i++) begin
            check($sformatf("presc_tick_c%0d", i), a_tick, ((i % 4) == 3) ? 1 : 0);
            cyc(1);
        end
        check("presc_upper", a_upper, 0);
        check("presc_lower", a_lower, 0);

        // ---------------- set clock to 23:59 / 11:59 ----------------
        repeat (23) pulse(2);
        repeat (59) pulse(1);
        check("set_a_upper", a_upper, 23);
        check("set_a_lower", a_lower, 59);
        check("set_b_upper", b_upper, 11);
        check("set_b_lower", b_lower, 59);
        for (int k = 0; k < 8 && !a_tick; k++) cyc(1);
        check("tick_sync", a_tick, 1);
        // add_sec coincident with tick: set wins, sec=0, prescaler at 0
        pulse(0);
        cyc(236);
        check("pre_wrap_a_upper", a_upper, 23);
        check("pre_wrap_a_lower", a_lower, 59);
        check("pre_wrap_b_upper", b_upper, 11);
        cyc(3);
        check("wrap_tick", a_tick, 1);
        check("wrap_hold_a_lower", a_lower, 59);
        cyc(1);
        check("wrap24_upper", a_upper, 0);
        check("wrap24_lower", a_lower, 0);
        check("wrap12_upper", b_upper, 0);
        check("wrap12_lower", b_lower, 0);
        pulse(1);
        check("add_min_after_wrap", a_lower, 1);

        // ---------------- stopwatch ----------------
        rst = 1'b1;
        #1;
        rst = 1'b0;
        mode = 2'b01;
        #1;
        check("sw_rst_lower", c_lower, 0);
        check("sw_rst_running", c_running, 0);
        pulse(3);
        check("sw_start_running", c_running, 1);
        check("sw_start_lower", c_lower, 0);
        cyc(5);
        check("sw_count5", c_lower, 5);
        pulse(4);
        check("sw_lap_active", c_lap, 1);
        check("sw_lap_lower", c_lower, 5);
        cyc(2);
        check("sw_lap_frozen", c_lower, 5);
        pulse(4);
        check("sw_lap_release", c_lap, 0);
        check("sw_live_after_release", c_lower, 9);
        pulse(3);
        check("sw_pause_running", c_running, 0);
        check("sw_pause_lower", c_lower, 9);
        cyc(2);
        check("sw_paused_hold", c_lower, 9);
        pulse(4);
        check("sw_lap_ignored_pause", c_lap, 0);
        pulse(5);
        check("sw_clear_lower", c_lower, 0);
        check("sw_clear_running", c_running, 0);
        pulse(3);
        cyc(3599);
        check("sw_5959_upper", c_upper, 59);
        check("sw_5959_lower", c_lower, 59);
        cyc(1);
        check("sw_wrap_upper", c_upper, 0);
        check("sw_wrap_lower", c_lower, 0);
        check("sw_wrap_running", c_running, 1);

        // ---------------- mode routing ----------------
        mode = 2'b00;
        #1;
        check("clk_mode_running", c_running, 1);
        cyc(4);
        pulse(3);
        cyc(5);
        mode = 2'b01;
        #1;
        check("route_sw_lower", c_lower, 10);
        check("route_sw_upper", c_upper, 0);
        check("route_sw_running", c_running, 1);
        pulse(4);
        check("route_lap_held", c_lap, 1);

`ifdef TK_COUNTDOWN_EN
        // ---------------- countdown ----------------
        mode = 2'b10;
        #1;
        check("cd_init_running", c_running, 0);
        check("cd_init_lower", c_lower, 0);
        pulse(3);
        check("cd_zero_preset_ignored", c_running, 0);
        repeat (3) pulse(0);
        check("cd_preset_lower", c_lower, 3);
        check("cd_preset_upper", c_upper, 0);
        pulse(3);
        check("cd_start_running", c_running, 1);
        check("cd_start_lower", c_lower, 3);
        for (int i = 2; i >= 0; i--) begin
            cyc(1);
            check($sformatf("cd_count_%0d", i), c_lower, i);
            check($sformatf("cd_exp_%0d", i), c_exp, (i == 0) ? 1 : 0);
        end
        check("cd_done_running", c_running, 0);
        cyc(2);
        check("cd_done_hold", c_lower, 0);
        pulse(3);
        check("cd_reload_exp", c_exp, 0);
        check("cd_reload_lower", c_lower, 3);
        pulse(3);
        cyc(2);
        check("cd_at_1", c_lower, 1);
        pulse(3);
        check("cd_pause_expire_exp", c_exp, 1);
        check("cd_pause_expire_lower", c_lower, 0);
        pulse(5);
        check("cd_clear_exp", c_exp, 0);
        check("cd_clear_lower", c_lower, 3);
        pulse(3);
        cyc(1);
        check("cd_at_2", c_lower, 2);
        rst = 1'b1;
        #1;
        check("mid_rst_upper", c_upper, 0);
        check("mid_rst_lower", c_lower, 0);
        check("mid_rst_tick", c_tick, 0);
        check("mid_rst_running", c_running, 0);
        check("mid_rst_lap", c_lap, 0);
        check("mid_rst_exp", c_exp, 0);
        check("mid_rst_a_lower", a_lower, 0);
        rst = 1'b0;
        #1;
        pulse(3);
        check("post_rst_preset_zero", c_running, 0);
        check("post_rst_lower", c_lower, 0);
`else
        // ---------------- no countdown: mode 10 acts as clock ----------------
        mode = 2'b10;
        #1;
        check("m10_running", c_running, 1);
        check("m10_exp", c_exp, 0);
        mode = 2'b01;
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_upper", c_upper, 0);
        check("mid_rst_lower", c_lower, 0);
        check("mid_rst_tick", c_tick, 0);
        check("mid_rst_running", c_running, 0);
        check("mid_rst_lap", c_lap, 0);
        check("mid_rst_exp", c_exp, 0);
        rst = 1'b0;
        mode = 2'b10;
        #1;
        check("post_rst_m10_running", c_running, 1);
        check("post_rst_m10_upper", c_upper, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
